// File: rtl/game_timer_ctrl_pkg.sv
// Shared definitions for the round-timer controller: state encodings,
// default counter width and the 6-bit binary-to-BCD helper.
package game_timer_ctrl_pkg;

   localparam int SEC_W_DEF = 6;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ARM   = 3'd1,
      ST_RUN   = 3'd2,
      ST_PAUSE = 3'd3,
      ST_DONE  = 3'd4
   } timer_state_t;

   // Split a 0..63 value into BCD tens (upper nibble) and ones (lower nibble).
   function automatic logic [7:0] bin2bcd(input logic [5:0] bin);
      return {4'(bin / 6'd10), 4'(bin % 6'd10)};
   endfunction

endpackage

// File: rtl/bin2bcd6.sv
// Registered 6-bit binary to two-digit BCD converter, one cycle of latency.
// The reset value is a parameter so the display comes out of reset
// already showing the value its source register resets to.
module bin2bcd6
   import game_timer_ctrl_pkg::*;
#(
   parameter logic [5:0] RST_BIN = 6'd0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] bin,
   output logic [3:0] tens,
   output logic [3:0] ones
);

   logic [7:0] bcd_reg;

   // Register the converted digits; reset shows the converted reset value.
   always_ff @(posedge clk) begin
      if (rst) begin
         bcd_reg <= bin2bcd(RST_BIN);
      end else begin
         bcd_reg <= bin2bcd(bin);
      end
   end

   assign tens = bcd_reg[7:4];
   assign ones = bcd_reg[3:0];

endmodule

// File: rtl/game_timer_ctrl.sv
// Round-timer controller driving sec_counter enable/clear and turning its
// elapsed-seconds value into remaining time, BCD digits, warn and time-up.
// Optional feature macro: TIMER_PAUSE_EN enables the PAUSED state and the
// pause_toggle input; without it pause_toggle is ignored.
module game_timer_ctrl
   import game_timer_ctrl_pkg::*;
#(
   parameter int GAME_SECONDS = 30,
   parameter int WARN_SECONDS = 5,
   parameter int SEC_W        = SEC_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             pause_toggle,
   input  logic [SEC_W-1:0] sec,
   output logic             cnt_enable,
   output logic             cnt_clear,
   output logic [SEC_W-1:0] remaining,
   output logic [3:0]       rem_tens,
   output logic [3:0]       rem_ones,
   output logic             running,
   output logic             warn,
   output logic             time_up,
   output logic             time_up_pulse
);

   // Comparisons are done one bit wider so GAME_SECONDS - sec never wraps.
   localparam logic [SEC_W:0]   GAME_EXT = (SEC_W+1)'(GAME_SECONDS);
   localparam logic [SEC_W:0]   WARN_EXT = (SEC_W+1)'(WARN_SECONDS);
   localparam logic [SEC_W-1:0] GAME_REM = SEC_W'(GAME_SECONDS);

   logic [SEC_W-1:0] s1_reg, s2_reg, sec_s_reg, sec_s_next;
   logic [SEC_W-1:0] remaining_reg, remaining_next, rem_calc;
   timer_state_t     state_reg, state_next;
   logic             cnt_enable_reg, cnt_clear_reg, running_reg;
   logic             warn_reg, warn_next, time_up_reg, time_up_pulse_reg;
   logic             expired;

`ifndef TIMER_PAUSE_EN
   logic unused_pause;
   assign unused_pause = pause_toggle;
`endif

   // sec comes from the 1 Hz domain: double-register it and accept a new
   // value only once two consecutive samples agree, so short glitches drop.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_reg    <= '0;
         s2_reg    <= '0;
         sec_s_reg <= '0;
      end else begin
         s1_reg    <= sec;
         s2_reg    <= s1_reg;
         sec_s_reg <= sec_s_next;
      end
   end

   // The FSM looks at the value sec_s is about to take, so state reacts on
   // the same edge that the stable sample is accepted.
   always_comb begin
      sec_s_next = (s1_reg == s2_reg) ? s2_reg : sec_s_reg;
      expired    = ({1'b0, sec_s_next} >= GAME_EXT);
   end

   // Next-state logic; priority is start, then expiry, then pause_toggle.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (start) state_next = ST_ARM;
         end
         ST_ARM: begin
            // Hold the clear until the counter reports zero back to us.
            if (start)                  state_next = ST_ARM;
            else if (sec_s_next == '0)  state_next = ST_RUN;
         end
         ST_RUN: begin
            if (start)             state_next = ST_ARM;
            else if (expired)      state_next = ST_DONE;
`ifdef TIMER_PAUSE_EN
            else if (pause_toggle) state_next = ST_PAUSE;
`endif
         end
`ifdef TIMER_PAUSE_EN
         ST_PAUSE: begin
            if (start)             state_next = ST_ARM;
            else if (pause_toggle) state_next = ST_RUN;
         end
`endif
         ST_DONE: begin
            if (start) state_next = ST_ARM;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Remaining time from the accepted sample, overridden by state:
   // full round in IDLE, zero in DONE, frozen while paused.
   always_comb begin
      rem_calc = ({1'b0, sec_s_reg} >= GAME_EXT) ? '0
               : SEC_W'(GAME_EXT - {1'b0, sec_s_reg});
      case (state_reg)
         ST_IDLE:  remaining_next = GAME_REM;
         ST_DONE:  remaining_next = '0;
`ifdef TIMER_PAUSE_EN
         ST_PAUSE: remaining_next = remaining_reg;
`endif
         default:  remaining_next = rem_calc;
      endcase
      warn_next = ((state_next == ST_RUN) || (state_next == ST_PAUSE)) &&
                  (remaining_next != '0) &&
                  ({1'b0, remaining_next} <= WARN_EXT);
   end

   // State register plus registered outputs decoded from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg         <= ST_IDLE;
         cnt_clear_reg     <= 1'b1;
         cnt_enable_reg    <= 1'b0;
         running_reg       <= 1'b0;
         time_up_reg       <= 1'b0;
         time_up_pulse_reg <= 1'b0;
         remaining_reg     <= GAME_REM;
         warn_reg          <= 1'b0;
      end else begin
         state_reg         <= state_next;
         cnt_clear_reg     <= (state_next == ST_IDLE) || (state_next == ST_ARM);
         cnt_enable_reg    <= (state_next == ST_RUN);
         running_reg       <= (state_next == ST_RUN);
         time_up_reg       <= (state_next == ST_DONE);
         time_up_pulse_reg <= (state_next == ST_DONE) && (state_reg != ST_DONE);
         remaining_reg     <= remaining_next;
         warn_reg          <= warn_next;
      end
   end

   bin2bcd6 #(
      .RST_BIN (6'(GAME_SECONDS))
   ) u_bcd (
      .clk  (clk),
      .rst  (rst),
      .bin  (remaining_reg),
      .tens (rem_tens),
      .ones (rem_ones)
   );

   assign cnt_enable    = cnt_enable_reg;
   assign cnt_clear     = cnt_clear_reg;
   assign remaining     = remaining_reg;
   assign running       = running_reg;
   assign warn          = warn_reg;
   assign time_up       = time_up_reg;
   assign time_up_pulse = time_up_pulse_reg;

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Scoreboard bench for game_timer_ctrl (GAME_SECONDS=30, WARN_SECONDS=5).
// Stimulus queues expected output values tagged with the cycle at which
// they must hold; a negedge monitor pops and compares them.
module tb_game_timer_ctrl;

`ifdef TIMER_PAUSE_EN
   localparam bit PEN = 1'b1;
`else
   localparam bit PEN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst, start, pause_toggle;
   logic [5:0] sec;
   logic       cnt_enable, cnt_clear, running, warn, time_up, time_up_pulse;
   logic [5:0] remaining;
   logic [3:0] rem_tens, rem_ones;

   game_timer_ctrl #(
      .GAME_SECONDS (30),
      .WARN_SECONDS (5),
      .SEC_W        (6)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .pause_toggle  (pause_toggle),
      .sec           (sec),
      .cnt_enable    (cnt_enable),
      .cnt_clear     (cnt_clear),
      .remaining     (remaining),
      .rem_tens      (rem_tens),
      .rem_ones      (rem_ones),
      .running       (running),
      .warn          (warn),
      .time_up       (time_up),
      .time_up_pulse (time_up_pulse)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef enum int {F_CLR, F_EN, F_REM, F_TENS, F_ONES, F_RUN, F_WARN, F_TU, F_TUP} field_t;
   typedef struct {
      int     at;
      field_t f;
      int     exp;
      string  name;
   } exp_t;

   exp_t sb[$];
   int   n_total = 0;
   int   n_pass  = 0;
   int   mon_got;

   function automatic int rd(field_t f);
      case (f)
         F_CLR:  return int'(cnt_clear);
         F_EN:   return int'(cnt_enable);
         F_REM:  return int'(remaining);
         F_TENS: return int'(rem_tens);
         F_ONES: return int'(rem_ones);
         F_RUN:  return int'(running);
         F_WARN: return int'(warn);
         F_TU:   return int'(time_up);
         F_TUP:  return int'(time_up_pulse);
         default: return -1;
      endcase
   endfunction

   // Queue an expectation 'ofs' cycles after the current edge.
   task automatic push_exp(input int ofs, input field_t f, input int v, input string nm);
      sb.push_back('{at: cyc + ofs, f: f, exp: v, name: nm});
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: compare every expectation due at this cycle.
   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].at == cyc) begin
            n_total++;
            mon_got = rd(sb[i].f);
            if (mon_got == sb[i].exp) begin
               n_pass++;
               $display("check %-8s cyc %0d: got %0d exp %0d ok", sb[i].name, cyc, mon_got, sb[i].exp);
            end else begin
               $display("FAIL %s cyc %0d: got %0d exp %0d", sb[i].name, cyc, mon_got, sb[i].exp);
            end
            sb.delete(i);
         end else if (sb[i].at < cyc) begin
            n_total++;
            $display("FAIL %s: check for cyc %0d missed at cyc %0d", sb[i].name, sb[i].at, cyc);
            sb.delete(i);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b0; pause_toggle = 1'b0; sec = 6'd0;

      // 1: reset values
      step(2);
      push_exp(0, F_CLR, 1, "rst_clr");   push_exp(0, F_EN, 0, "rst_en");
      push_exp(0, F_REM, 30, "rst_rem");  push_exp(0, F_TENS, 3, "rst_tens");
      push_exp(0, F_ONES, 0, "rst_ones"); push_exp(0, F_TU, 0, "rst_tu");
      push_exp(0, F_RUN, 0, "rst_run");   push_exp(0, F_WARN, 0, "rst_warn");
      step(1);
      rst = 1'b0;

      // 2: start with sec held at 7, then counter reports 0
      sec = 6'd7;
      step(5);
      start = 1'b1; step(1); start = 1'b0;
      push_exp(0, F_CLR, 1, "arm_clr"); push_exp(0, F_EN, 0, "arm_en");
      sec = 6'd0;
      push_exp(2, F_EN, 0, "arm_hold"); push_exp(3, F_EN, 1, "run_en");
      push_exp(3, F_CLR, 0, "run_clr"); push_exp(3, F_RUN, 1, "run_run");
      push_exp(4, F_REM, 30, "run_rem");
      step(5);

      // 3: count a full round
      for (int v = 1; v <= 30; v++) begin
         sec = 6'(v);
         push_exp(4, F_REM, 30 - v, "cnt_rem");
         push_exp(4, F_WARN, (v >= 25 && v <= 29) ? 1 : 0, "cnt_warn");
         if (v == 10) begin push_exp(5, F_TENS, 2, "tens20"); push_exp(5, F_ONES, 0, "ones20"); end
         if (v == 17) begin push_exp(5, F_TENS, 1, "tens13"); push_exp(5, F_ONES, 3, "ones13"); end
         if (v == 25) begin push_exp(5, F_TENS, 0, "tens5");  push_exp(5, F_ONES, 5, "ones5");  end
         if (v == 30) begin
            push_exp(2, F_EN, 1, "pre_done"); push_exp(3, F_EN, 0, "done_en");
            push_exp(3, F_TUP, 1, "tup");     push_exp(4, F_TUP, 0, "tup_end");
            push_exp(3, F_TU, 1, "tu");
         end else begin
            push_exp(4, F_TUP, 0, "no_tup");
         end
         step(3);
      end
      sec = 6'd31;
      push_exp(5, F_REM, 0, "done31"); push_exp(5, F_TU, 1, "tu31"); push_exp(5, F_TUP, 0, "tup31");
      step(3);
      sec = 6'd0;
      push_exp(5, F_REM, 0, "done0");   push_exp(5, F_TENS, 0, "done_t");
      push_exp(5, F_ONES, 0, "done_o"); push_exp(5, F_TU, 1, "tu0");
      step(6);

      // 4: pause at sec=12
      start = 1'b1; step(1); start = 1'b0;
      push_exp(0, F_CLR, 1, "rearm"); push_exp(1, F_EN, 1, "rerun"); push_exp(2, F_REM, 30, "rerem");
      step(3);
      for (int v = 1; v <= 12; v++) begin
         sec = 6'(v);
         step(3);
      end
      step(3);
      push_exp(0, F_REM, 18, "rem12");
      pause_toggle = 1'b1; step(1); pause_toggle = 1'b0;
      push_exp(0, F_EN, PEN ? 0 : 1, "pause_en"); push_exp(0, F_RUN, PEN ? 0 : 1, "pause_run");
      sec = 6'd13;
      step(6);
      push_exp(0, F_REM, PEN ? 18 : 17, "pause_rem"); push_exp(0, F_EN, PEN ? 0 : 1, "pause_en2");
      pause_toggle = 1'b1; step(1); pause_toggle = 1'b0;
      push_exp(0, F_EN, 1, "resume_en"); push_exp(0, F_RUN, 1, "resume_run");
      push_exp(1, F_REM, 17, "resume_rem");
      step(3);

      // 5: start and pause_toggle together at sec=20, then a sec glitch
      sec = 6'd20;
      step(5);
      push_exp(0, F_REM, 10, "rem20");
      start = 1'b1; pause_toggle = 1'b1; step(1); start = 1'b0; pause_toggle = 1'b0;
      push_exp(0, F_CLR, 1, "both_clr"); push_exp(0, F_EN, 0, "both_en"); push_exp(0, F_RUN, 0, "both_run");
      sec = 6'd0;
      push_exp(2, F_EN, 0, "arm2_hold"); push_exp(3, F_EN, 1, "arm2_run"); push_exp(3, F_CLR, 0, "arm2_clr");
      step(5);
      sec = 6'd20;
      step(5);
      push_exp(0, F_REM, 10, "pre_glit");
      sec = 6'd5;
      for (int k = 2; k <= 6; k++) push_exp(k, F_REM, 10, "glitch");
      push_exp(6, F_WARN, 0, "glit_warn");
      step(1);
      sec = 6'd20;
      step(7);

      // 6: reset mid-round, then re-arm
      sec = 6'd15;
      step(6);
      push_exp(0, F_REM, 15, "rem15"); push_exp(0, F_TENS, 1, "tens15"); push_exp(0, F_ONES, 5, "ones15");
      rst = 1'b1; step(1); rst = 1'b0;
      push_exp(0, F_CLR, 1, "mrst_clr");   push_exp(0, F_EN, 0, "mrst_en");
      push_exp(0, F_REM, 30, "mrst_rem");  push_exp(0, F_TENS, 3, "mrst_tens");
      push_exp(0, F_ONES, 0, "mrst_ones"); push_exp(0, F_RUN, 0, "mrst_run");
      push_exp(0, F_WARN, 0, "mrst_warn"); push_exp(0, F_TU, 0, "mrst_tu");
      push_exp(0, F_TUP, 0, "mrst_tup");
      step(5);
      push_exp(0, F_REM, 30, "idle_rem");
      start = 1'b1; step(1); start = 1'b0;
      push_exp(0, F_CLR, 1, "rst_arm"); push_exp(0, F_EN, 0, "rst_arm_en");
      sec = 6'd0;
      push_exp(2, F_EN, 0, "rst_hold"); push_exp(3, F_EN, 1, "rst_run");
      push_exp(3, F_RUN, 1, "rst_running"); push_exp(4, F_REM, 30, "rst_rem30");
      push_exp(5, F_TENS, 3, "rst_tens30");
      step(8);

      // Anything still queued was never reached.
      while (sb.size() != 0) begin
         n_total++;
         $display("FAIL %s: check for cyc %0d never reached", sb[0].name, sb[0].at);
         sb.delete(0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
